// File: rtl/bidim_rr_arb_pkg.sv
// Shared types and helpers for the round-robin lane arbiter.
package bidim_rr_arb_pkg;

  // Occupancy of the single output register slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Index that follows idx in a ring of depth entries (wraps to 0 after depth-1).
  function automatic int wrap_next(input int idx, input int depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bidim_mux.sv
// Lane selector: returns the WIDTH-bit lane addressed by sel from a packed lane bus.
module bidim_mux #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic [WIDTH*DEPTH-1:0]     in_data,
  input  logic [$clog2(DEPTH)-1:0]   sel,
  output logic [WIDTH-1:0]           out_data
);

  localparam int SEL_WIDTH = $clog2(DEPTH);

  // Pick the addressed lane; an index past the last lane yields zero.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        out_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/bidim_rr_arb.sv
// Round-robin arbiter feeding one registered output slot with valid/ready on both sides.
module bidim_rr_arb
  import bidim_rr_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH*DEPTH-1:0]     in_data,
  input  logic [DEPTH-1:0]           in_valid,
  output logic [DEPTH-1:0]           in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH)-1:0]   out_sel,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int SEL_WIDTH  = $clog2(DEPTH);
  localparam int TOTAL_BITS = WIDTH * DEPTH;

  slot_state_t            state_q;
  slot_state_t            state_d;
  logic [SEL_WIDTH-1:0]   ptr_q;
  logic [SEL_WIDTH-1:0]   ptr_d;
  logic [SEL_WIDTH-1:0]   grant;
  logic [SEL_WIDTH-1:0]   grant_hi;
  logic [SEL_WIDTH-1:0]   grant_lo;
  logic                   found_hi;
  logic                   any_valid;
  logic                   loadable;
  logic                   load;
  logic [TOTAL_BITS-1:0]  lane_bus;
  logic [WIDTH-1:0]       mux_data;

  assign lane_bus  = in_data;
  assign any_valid = |in_valid;
  // Reset blocks loading so nothing is accepted during a reset cycle.
  assign loadable  = rst_n && ((state_q == SLOT_EMPTY) || out_ready);
  assign load      = loadable && any_valid;
  assign ptr_d     = SEL_WIDTH'(wrap_next(int'(grant), DEPTH));

  // Round-robin search: lowest valid lane at or above ptr, otherwise lowest valid lane overall.
  always_comb begin
    found_hi = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        grant_lo = SEL_WIDTH'(i);
        if (SEL_WIDTH'(i) >= ptr_q) begin
          found_hi = 1'b1;
          grant_hi = SEL_WIDTH'(i);
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  bidim_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mux (
    .in_data  (lane_bus),
    .sel      (grant),
    .out_data (mux_data)
  );

  // Slot state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot fills on a grant, empties when it can load but nobody requests, otherwise holds.
  always_comb begin
    state_d = state_q;
    if (loadable) begin
      state_d = any_valid ? SLOT_FULL : SLOT_EMPTY;
    end
  end

  // Handshake outputs: one-hot accept for the granted lane only in a loading cycle.
  always_comb begin
    out_valid = (state_q == SLOT_FULL);
    in_ready  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      in_ready[i] = load && (grant == SEL_WIDTH'(i));
    end
  end

  // Output word, source index and round-robin pointer update only on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr_q    <= '0;
    end else if (load) begin
      out_data <= mux_data;
      out_sel  <= grant;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_bidim_rr_arb.sv
// Self-checking bench for bidim_rr_arb: directed scenarios plus randomized traffic against a queue-free ring model.
module tb_bidim_rr_arb;

  localparam int D = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  logic         rst3_n;
  logic [5:0]   d3;
  logic [2:0]   v3;
  logic [2:0]   ir3;
  logic [1:0]   od3;
  logic [1:0]   os3;
  logic         ov3;
  logic         r3;

  int           n_checks;
  int           n_fail;
  bit           check_en;

  logic         m_valid;
  logic [1:0]   m_data;
  int           m_sel;
  int           m_ptr;

  bidim_rr_arb #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  bidim_rr_arb #(.WIDTH(2), .DEPTH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst3_n),
    .in_data   (d3),
    .in_valid  (v3),
    .in_ready  (ir3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_valid (ov3),
    .out_ready (r3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting lane walking upward around the ring from p, or -1 if none.
  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < D; k++) begin
      int idx;
      idx = (p + k) % D;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    if (rst_n !== 1'b1) return 4'b0000;
    if (m_valid && !out_ready) return 4'b0000;
    g = model_grant(in_valid, m_ptr);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  // Reference model advances on every rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    int g;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0;
      m_data  = 2'b00;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (!m_valid || out_ready) begin
      g = model_grant(in_valid, m_ptr);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
        m_ptr   = (g + 1) % D;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_out_valid", 32'(out_valid), 32'(m_valid));
      check_output("model_out_data", 32'(out_data), 32'(m_data));
      check_output("model_out_sel", 32'(out_sel), 32'(m_sel));
      check_output("model_in_ready", 32'(in_ready), 32'(model_ready()));
    end
  end

  task automatic apply_stimulus(input logic rst, input logic [3:0] v, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    rst_n     = rst;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    check_en  = 1'b0;
    m_valid   = 1'b0;
    m_data    = 2'b00;
    m_sel     = 0;
    m_ptr     = 0;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 8'hE4;
    out_ready = 1'b1;
    rst3_n    = 1'b0;
    v3        = 3'b111;
    d3        = {2'd2, 2'd1, 2'd0};
    r3        = 1'b1;

    // Reset with all lanes requesting.
    apply_stimulus(1'b0, 4'b1111, 8'hE4, 1'b1);
    apply_stimulus(1'b0, 4'b1111, 8'hE4, 1'b1);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_out_sel", 32'(out_sel), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_en = 1'b1;

    // Round robin over lanes holding data 0,1,2,3.
    apply_stimulus(1'b1, 4'b1111, 8'hE4, 1'b1);
    check_output("rr_first_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 4'b1111, 8'hE4, 1'b1);
      check_output("rr_valid", 32'(out_valid), 32'd1);
      check_output("rr_sel", 32'(out_sel), 32'(k % 4));
      check_output("rr_data", 32'(out_data), 32'(k % 4));
      check_output("rr_ready", 32'(in_ready), 32'(1 << ((k + 1) % 4)));
    end

    // Back-pressure after a single word from lane 0.
    apply_stimulus(1'b0, 4'b0000, 8'hC6, 1'b1);
    apply_stimulus(1'b1, 4'b0001, 8'hC6, 1'b1);
    check_output("bp_first_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 4'b1111, 8'hC6, 1'b0);
      check_output("bp_hold_valid", 32'(out_valid), 32'd1);
      check_output("bp_hold_data", 32'(out_data), 32'h2);
      check_output("bp_hold_sel", 32'(out_sel), 32'd0);
      check_output("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    apply_stimulus(1'b1, 4'b1111, 8'hC6, 1'b1);
    check_output("bp_release_ready", 32'(in_ready), 32'h2);
    apply_stimulus(1'b1, 4'b1111, 8'hC6, 1'b0);
    check_output("bp_next_valid", 32'(out_valid), 32'd1);
    check_output("bp_next_sel", 32'(out_sel), 32'd1);
    check_output("bp_next_data", 32'(out_data), 32'h1);

    // Reset while full with the downstream stalled.
    apply_stimulus(1'b0, 4'b1111, 8'hC6, 1'b0);
    check_output("mrst_ready_in_reset", 32'(in_ready), 32'd0);
    check_output("mrst_still_full", 32'(out_valid), 32'd1);
    apply_stimulus(1'b1, 4'b0110, 8'hC6, 1'b0);
    check_output("mrst_valid_dropped", 32'(out_valid), 32'd0);
    check_output("mrst_sel_cleared", 32'(out_sel), 32'd0);
    check_output("mrst_data_cleared", 32'(out_data), 32'd0);
    check_output("mrst_lowest_lane", 32'(in_ready), 32'h2);
    apply_stimulus(1'b1, 4'b0000, 8'hC6, 1'b1);
    check_output("mrst_first_sel", 32'(out_sel), 32'd1);

    // Sparse request with wrap: ptr reaches 3, then lane 1 wraps ptr to 2.
    apply_stimulus(1'b1, 4'b0100, 8'hC6, 1'b1);
    check_output("wrap_lane2_ready", 32'(in_ready), 32'h4);
    apply_stimulus(1'b1, 4'b0010, 8'hC6, 1'b1);
    check_output("wrap_sel2", 32'(out_sel), 32'd2);
    check_output("wrap_lane1_ready", 32'(in_ready), 32'h2);
    apply_stimulus(1'b1, 4'b0000, 8'hC6, 1'b1);
    check_output("wrap_sel1", 32'(out_sel), 32'd1);
    check_output("wrap_idle_ready", 32'(in_ready), 32'd0);
    apply_stimulus(1'b1, 4'b1111, 8'hC6, 1'b1);
    check_output("wrap_empty", 32'(out_valid), 32'd0);
    check_output("wrap_sel_held", 32'(out_sel), 32'd1);
    check_output("wrap_ptr_held", 32'(in_ready), 32'h4);

    // Randomized traffic, occasional resets.
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0,
                     4'($urandom()), 8'($urandom()),
                     ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    check_en = 1'b0;

    // Three-lane instance: pointer must cycle 0,1,2 and never produce 3.
    @(posedge clk);
    #1;
    rst3_n = 1'b1;
    @(negedge clk);
    check_output("d3_first_ready", 32'(ir3), 32'h1);
    check_output("d3_empty", 32'(ov3), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("d3_valid", 32'(ov3), 32'd1);
      check_output("d3_sel", 32'(os3), 32'(k % 3));
      check_output("d3_data", 32'(od3), 32'(k % 3));
      check_output("d3_sel_in_range", 32'(os3 < 2'd3), 32'd1);
      check_output("d3_ready", 32'(ir3), 32'(1 << ((k + 1) % 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
